// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM states
// and a helper that classifies ops as signed.
package muldiv_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_MADD  = 4'd3;
    localparam logic [3:0] OP_MADDU = 4'd4;
    localparam logic [3:0] OP_MSUB  = 4'd5;
    localparam logic [3:0] OP_MSUBU = 4'd6;
    localparam logic [3:0] OP_DIV   = 4'd7;
    localparam logic [3:0] OP_DIVU  = 4'd8;
    localparam logic [3:0] OP_MTHI  = 4'd9;
    localparam logic [3:0] OP_MTLO  = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_ITER = 2'd1,
        ST_DIV_ITER = 2'd2,
        ST_FINISH   = 2'd3
    } state_t;

    function automatic logic is_signed(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB) || (op == OP_DIV);
    endfunction

    function automatic logic is_mul(input logic [3:0] op);
        return (op >= OP_MULT) && (op <= OP_MSUBU);
    endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Issue/result bundle between the EX stage (master) and the muldiv unit (slave).
interface hilo_muldiv_unit_if #(parameter int WIDTH = 32);
    import muldiv_pkg::*;

    // start is taken only while busy=0 and flush=0; while busy=1 the issuer
    // holds the instruction. done pulses once with HI/LO already updated.
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    state_t           state;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, div_by_zero, hi, lo, state
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, div_by_zero, hi, lo, state
    );

endinterface

// File: rtl/muldiv_iter_core.sv
// Shared radix-2 datapath: shift-add multiply or restoring divide, one bit per step.
// upper/lower hold {product_hi, product_lo} or {remainder, quotient}.
module muldiv_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             div_mode,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             last,
    output logic [WIDTH-1:0] upper,
    output logic [WIDTH-1:0] lower
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [CNT_W-1:0] count;
    logic             mode;
    logic [WIDTH-1:0] m;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] diff;

    always_comb begin
        mul_sum = {1'b0, upper} + {1'b0, (lower[0] ? m : '0)};
        shifted = {upper, lower[WIDTH-1]};
        fits    = shifted >= {1'b0, m};
        // Remainder after a successful subtract is below m, so WIDTH bits suffice.
        diff    = shifted[WIDTH-1:0] - m;
    end

    assign last = (count == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upper <= '0;
            lower <= '0;
            m     <= '0;
            count <= '0;
            mode  <= 1'b0;
        end else if (load) begin
            upper <= '0;
            lower <= opa;
            m     <= opb;
            count <= '0;
            mode  <= div_mode;
        end else if (step) begin
            count <= count + 1'b1;
            if (mode) begin
                if (fits) begin
                    upper <= diff;
                    lower <= {lower[WIDTH-2:0], 1'b1};
                end else begin
                    upper <= shifted[WIDTH-1:0];
                    lower <= {lower[WIDTH-2:0], 1'b0};
                end
            end else begin
                upper <= mul_sum[WIDTH:1];
                lower <= {mul_sum[0], lower[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO owner for the CPU: FSM, sign fix-up, madd/msub accumulate and the
// HI/LO registers around the shared iterative multiply/divide core.
module hilo_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    hilo_muldiv_unit_if.slave    bus
);
    state_t           state;
    logic [3:0]       op_q;
    logic             neg_p;
    logic             neg_r;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;

    logic             op_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             accept;
    logic             core_load;
    logic             core_step;
    logic             core_last;
    logic [WIDTH-1:0] core_upper;
    logic [WIDTH-1:0] core_lower;

    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] hilo_cur;
    logic [2*WIDTH-1:0] hilo_mul;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    always_comb begin
        op_signed = is_signed(bus.op);
        a_neg     = op_signed & bus.a[WIDTH-1];
        b_neg     = op_signed & bus.b[WIDTH-1];
        // -2^(W-1) maps onto itself, which is already the right unsigned magnitude.
        a_mag     = a_neg ? -bus.a : bus.a;
        b_mag     = b_neg ? -bus.b : bus.b;
        accept    = (state == ST_IDLE) && bus.start && !bus.flush;
        core_load = accept && (is_mul(bus.op) ||
                    (((bus.op == OP_DIV) || (bus.op == OP_DIVU)) && (bus.b != '0)));
        core_step = ((state == ST_MUL_ITER) || (state == ST_DIV_ITER)) && !bus.flush;
    end

    muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (core_load),
        .step     (core_step),
        .div_mode ((bus.op == OP_DIV) || (bus.op == OP_DIVU)),
        .opa      (a_mag),
        .opb      (b_mag),
        .last     (core_last),
        .upper    (core_upper),
        .lower    (core_lower)
    );

    always_comb begin
        prod_mag = {core_upper, core_lower};
        prod     = neg_p ? -prod_mag : prod_mag;
        hilo_cur = {hi_q, lo_q};
        case (op_q)
            OP_MADD, OP_MADDU: hilo_mul = hilo_cur + prod;
            OP_MSUB, OP_MSUBU: hilo_mul = hilo_cur - prod;
            default:           hilo_mul = prod;
        endcase
        quot = neg_p ? -core_lower : core_lower;
        rem  = neg_r ? -core_upper : core_upper;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            op_q   <= OP_NOP;
            neg_p  <= 1'b0;
            neg_r  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            if (bus.flush && (state != ST_IDLE)) begin
                state  <= ST_IDLE;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            op_q  <= bus.op;
                            neg_p <= a_neg ^ b_neg;
                            neg_r <= a_neg;
                            case (bus.op)
                                OP_MTHI: begin
                                    hi_q   <= bus.a;
                                    done_q <= 1'b1;
                                end
                                OP_MTLO: begin
                                    lo_q   <= bus.a;
                                    done_q <= 1'b1;
                                end
                                OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                                    state  <= ST_MUL_ITER;
                                    busy_q <= 1'b1;
                                end
                                OP_DIV, OP_DIVU: begin
                                    if (bus.b == '0) begin
                                        done_q <= 1'b1;
                                        dbz_q  <= 1'b1;
                                    end else begin
                                        state  <= ST_DIV_ITER;
                                        busy_q <= 1'b1;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                    ST_MUL_ITER, ST_DIV_ITER: begin
                        if (core_last) state <= ST_FINISH;
                    end
                    ST_FINISH: begin
                        if ((op_q == OP_DIV) || (op_q == OP_DIVU)) begin
                            lo_q <= quot;
                            hi_q <= rem;
                        end else begin
                            {hi_q, lo_q} <= hilo_mul;
                        end
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.state       = state;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit at WIDTH=32: multiply, accumulate,
// divide, divide-by-zero, flush, ignored start and asynchronous reset.
module tb_hilo_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    hilo_muldiv_unit_if #(.WIDTH(W)) bus ();

    hilo_muldiv_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; returns at the negedge sample where done is seen.
    // lat counts clock edges after the start edge; busy_cnt counts busy samples.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int busy_cnt);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        busy_cnt = 0;
        while (!bus.done && lat < 100) begin
            if (bus.busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        checks++; if (bus.hi !== '0) begin failures++; $display("FAIL reset_hi: got %h expected 0", bus.hi); end
        checks++; if (bus.lo !== '0) begin failures++; $display("FAIL reset_lo: got %h expected 0", bus.lo); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        checks++; if (bus.div_by_zero !== 1'b0) begin failures++; $display("FAIL reset_dbz: got %b expected 0", bus.div_by_zero); end
        checks++; if (bus.state !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %0d expected %0d", bus.state, ST_IDLE); end
    endtask

    task automatic test_mult_signed();
        int lat, bc;
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, lat, bc);
        checks++; if (lat != 33) begin failures++; $display("FAIL mult_latency: got %0d expected 33", lat); end
        checks++; if (bc != 33) begin failures++; $display("FAIL mult_busy_cycles: got %0d expected 33", bc); end
        checks++; if (bus.hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_hi: got %h expected ffffffff", bus.hi); end
        checks++; if (bus.lo !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mult_lo: got %h expected ffffffeb", bus.lo); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL mult_done_width: got %b expected 0", bus.done); end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
        checks++; if (bus.hi !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_hi: got %h expected fffffffe", bus.hi); end
        checks++; if (bus.lo !== 32'h0000_0001) begin failures++; $display("FAIL multu_lo: got %h expected 00000001", bus.lo); end
        // Issue the next op in the very cycle done is high.
        run_op(OP_MULT, 32'd6, 32'hFFFF_FFF9, lat, bc);
        checks++; if (lat != 33) begin failures++; $display("FAIL b2b_latency: got %0d expected 33", lat); end
        checks++; if (bus.hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL b2b_hi: got %h expected ffffffff", bus.hi); end
        checks++; if (bus.lo !== 32'hFFFF_FFD6) begin failures++; $display("FAIL b2b_lo: got %h expected ffffffd6", bus.lo); end
    endtask

    task automatic test_accumulate();
        int lat, bc;
        run_op(OP_MTHI, 32'd0, 32'd0, lat, bc);
        checks++; if (lat != 0 || bc != 0) begin failures++; $display("FAIL mthi_timing: got lat=%0d busy=%0d expected 0/0", lat, bc); end
        run_op(OP_MTLO, 32'd5, 32'd0, lat, bc);
        checks++; if (bus.lo !== 32'd5) begin failures++; $display("FAIL mtlo_lo: got %h expected 00000005", bus.lo); end
        run_op(OP_MADD, 32'd2, 32'd3, lat, bc);
        checks++; if (bus.hi !== 32'd0) begin failures++; $display("FAIL madd_hi: got %h expected 0", bus.hi); end
        checks++; if (bus.lo !== 32'd11) begin failures++; $display("FAIL madd_lo: got %h expected 0000000b", bus.lo); end
        run_op(OP_MSUB, 32'd4, 32'd4, lat, bc);
        checks++; if (bus.hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL msub_hi: got %h expected ffffffff", bus.hi); end
        checks++; if (bus.lo !== 32'hFFFF_FFFB) begin failures++; $display("FAIL msub_lo: got %h expected fffffffb", bus.lo); end
        run_op(OP_MADDU, 32'd3, 32'd2, lat, bc);
        checks++; if ({bus.hi, bus.lo} !== 64'd1) begin failures++; $display("FAIL maddu_hilo: got %h expected 1", {bus.hi, bus.lo}); end
    endtask

    task automatic test_divide();
        int lat, bc;
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, bc);
        checks++; if (lat != 33) begin failures++; $display("FAIL div_latency: got %0d expected 33", lat); end
        checks++; if (bus.lo !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_lo: got %h expected fffffffd", bus.lo); end
        checks++; if (bus.hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_hi: got %h expected ffffffff", bus.hi); end
        run_op(OP_DIVU, 32'd100, 32'd7, lat, bc);
        checks++; if (bus.lo !== 32'd14 || bus.hi !== 32'd2) begin failures++; $display("FAIL divu: got hi=%h lo=%h expected 2/e", bus.hi, bus.lo); end
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
        checks++; if (bus.lo !== 32'h8000_0000) begin failures++; $display("FAIL div_ovf_lo: got %h expected 80000000", bus.lo); end
        checks++; if (bus.hi !== 32'd0) begin failures++; $display("FAIL div_ovf_hi: got %h expected 0", bus.hi); end
        checks++; if (bus.div_by_zero !== 1'b0) begin failures++; $display("FAIL div_ovf_dbz: got %b expected 0", bus.div_by_zero); end
        run_op(OP_DIVU, 32'd7, 32'd0, lat, bc);
        checks++; if (lat != 0) begin failures++; $display("FAIL dbz_latency: got %0d expected 0", lat); end
        checks++; if (bus.div_by_zero !== 1'b1) begin failures++; $display("FAIL dbz_flag: got %b expected 1", bus.div_by_zero); end
        checks++; if (bus.lo !== 32'h8000_0000 || bus.hi !== 32'd0) begin failures++; $display("FAIL dbz_hold: got hi=%h lo=%h expected 0/80000000", bus.hi, bus.lo); end
        @(negedge clk);
        checks++; if (bus.div_by_zero !== 1'b0 || bus.done !== 1'b0) begin failures++; $display("FAIL dbz_pulse: got dbz=%b done=%b expected 0/0", bus.div_by_zero, bus.done); end
    endtask

    task automatic test_flush();
        int lat, bc;
        logic saw_done;
        bus.start = 1'b1; bus.op = OP_MULT; bus.a = 32'd5; bus.b = 32'd6;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL flush_busy: got %b expected 0", bus.busy); end
        saw_done = 1'b0;
        repeat (40) begin
            if (bus.done) saw_done = 1'b1;
            @(negedge clk);
        end
        checks++; if (saw_done !== 1'b0) begin failures++; $display("FAIL flush_no_done: got %b expected 0", saw_done); end
        checks++; if (bus.lo !== 32'h8000_0000 || bus.hi !== 32'd0) begin failures++; $display("FAIL flush_hold: got hi=%h lo=%h expected 0/80000000", bus.hi, bus.lo); end
        // Start coinciding with flush in IDLE must be dropped.
        bus.start = 1'b1; bus.op = OP_MTLO; bus.a = 32'd77; bus.flush = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        checks++; if (bus.done !== 1'b0 || bus.lo !== 32'h8000_0000) begin failures++; $display("FAIL flush_start: got done=%b lo=%h expected 0/80000000", bus.done, bus.lo); end
        // A start pulsed while busy is ignored.
        bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'd3; bus.b = 32'd4;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MTLO; bus.a = 32'h1234;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 6;
        while (!bus.done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (lat != 33) begin failures++; $display("FAIL ignore_latency: got %0d expected 33", lat); end
        checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd12) begin failures++; $display("FAIL ignore_result: got hi=%h lo=%h expected 0/c", bus.hi, bus.lo); end
        @(negedge clk);
        checks++; if (bus.lo !== 32'd12 || bus.done !== 1'b0) begin failures++; $display("FAIL ignore_after: got lo=%h done=%b expected c/0", bus.lo, bus.done); end
    endtask

    task automatic test_async_reset();
        int lat, bc;
        run_op(OP_MTHI, 32'hABCD, 32'd0, lat, bc);
        bus.start = 1'b1; bus.op = OP_DIV; bus.a = 32'd100; bus.b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.hi !== '0 || bus.lo !== '0) begin failures++; $display("FAIL async_hilo: got hi=%h lo=%h expected 0/0", bus.hi, bus.lo); end
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin failures++; $display("FAIL async_flags: got busy=%b done=%b expected 0/0", bus.busy, bus.done); end
        checks++; if (bus.state !== ST_IDLE) begin failures++; $display("FAIL async_state: got %0d expected %0d", bus.state, ST_IDLE); end
        @(negedge clk);
        rst = 1'b0;
        run_op(OP_MTLO, 32'd9, 32'd0, lat, bc);
        checks++; if (bus.lo !== 32'd9 || bus.hi !== 32'd0) begin failures++; $display("FAIL post_reset_mtlo: got hi=%h lo=%h expected 0/9", bus.hi, bus.lo); end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = OP_NOP;
        bus.a     = '0;
        bus.b     = '0;
        bus.flush = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_mult_signed();
        test_back_to_back();
        test_accumulate();
        test_divide();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
Parametrised iterative multiply/divide unit that owns the HI/LO register pair for the pipelined CPU. The EX stage issues an operation with a one-cycle start pulse. The unit runs a radix-2 shift-add multiply or restoring divide over WIDTH cycles, with signed/unsigned variants and HI/LO accumulate/subtract (madd/msub). The pipeline stalls any mfhi/mflo or new muldiv issue while busy is high.

Parameters:
WIDTH, 32, operand width and width of each of HI and LO; legal values are 4..64.
CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, never overridden.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  reset, asynchronous and active-high.
start  in  1  issue strobe; sampled only while busy=0.
op  in  4  operation code, encoded by muldiv_pkg: NOP, MULT, MULTU, MADD, MADDU, MSUB, MSUBU, DIV, DIVU, MTHI, MTLO.
a  in  WIDTH  rs operand; dividend for DIV/DIVU.
b  in  WIDTH  rt operand; divisor for DIV/DIVU.
flush  in  1  pipeline flush; aborts any in-flight operation.
busy  out  1  operation in flight; the pipeline must stall on this.
done  out  1  one-cycle pulse; HI/LO are updated in the same cycle.
div_by_zero  out  1  one-cycle pulse, coincident with done, for DIV/DIVU with b=0.
hi  out  WIDTH  HI register.
lo  out  WIDTH  LO register.

Behaviour:
- Reset: hi=0, lo=0, busy=0, done=0, div_by_zero=0, state=IDLE, counter=0. Reset is asynchronous and overrides every other input, including mid-operation.
- States: IDLE, MUL_ITER, DIV_ITER, FINISH.
- IDLE, start=1, flush=0:
  - MTHI/MTLO: hi or lo <= a at that edge. busy stays 0, done=1 in the next cycle.
  - Multiply ops: latch |a| and |b| (or raw values for unsigned ops), result sign = a[W-1]^b[W-1] for signed ops. Go to MUL_ITER, counter=0, busy=1.
  - DIV/DIVU with b!=0: latch magnitudes and both signs, go to DIV_ITER.
  - DIV/DIVU with b=0: no iteration. done=1 and div_by_zero=1 in the next cycle, HI/LO unchanged.
  - NOP: no effect.
- MUL_ITER: one shift-add step per cycle, WIDTH cycles, then FINISH.
- DIV_ITER: one restoring step per cycle, WIDTH cycles, then FINISH.
- FINISH (one cycle), result computed on 2*WIDTH bits with wrap-around:
  - Signed ops: apply two's-complement negation when the sign bit is set.
  - MULT/MULTU: {hi,lo} <= product.
  - MADD/MADDU: {hi,lo} <= {hi,lo} + product.
  - MSUB/MSUBU: {hi,lo} <= {hi,lo} - product.
  - DIV/DIVU: lo <= quotient, hi <= remainder. For DIV, quotient sign = sa^sb and remainder sign = dividend sign.
  - DIV of -2^(W-1) by -1 gives lo=-2^(W-1), hi=0 (natural wrap, no flag).
  - At the FINISH edge: done=1 and the new HI/LO are visible, busy returns to 0, state=IDLE.
- Latency: done and the new HI/LO appear exactly WIDTH+1 cycles after the start edge for a multiply or a nonzero divide.
- busy is 1 from the cycle after start through the FINISH cycle.
- A new start is accepted in the same cycle done is high.
- start while busy=1 is ignored; the issuing stage must hold the instruction.
- flush=1 in any non-IDLE state: return to IDLE at that edge, busy=0 next cycle, no done, HI/LO unchanged.
- flush=1 together with start in IDLE: start is ignored.
- Accumulate ops read hi/lo at FINISH. These cannot change while busy, because MTHI/MTLO are only accepted in IDLE.

Decomposition:
- muldiv_pkg holds the op localparams (4-bit), the state encoding, and an is_signed(op) helper function.
- One sub-module, muldiv_iter_core, holds the shared shift register, partial remainder/product and counter. It exposes load, step and last.
- The top level keeps the FSM, sign fix-up, accumulate adder and the HI/LO registers.

Test Plan:
1. W=32, MULT a=0xFFFFFFFD (-3), b=7 -> after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB; done high exactly one cycle; busy high for 33 cycles.
2. MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Second start issued in the done cycle is accepted.
3. MTHI 0, MTLO 5, then MADD 2,3 -> hi=0, lo=11. Then MSUB 4,4 -> hi=0xFFFFFFFF, lo=0xFFFFFFFB.
4. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 7/0 -> done and div_by_zero pulse next cycle, HI/LO unchanged.
5. MULT started, flush at iteration 10 -> busy=0 next cycle, no done, HI/LO hold old values. A start pulsed mid-operation is ignored, with HI/LO matching a single-op result.
6. rst asserted asynchronously mid-DIV (between clock edges) -> hi, lo, busy, done read 0 immediately. After release, MTLO 9 -> lo=9.
